// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, tick-timed debounce, level plus
// press/release/long/repeat pulses per key. One prescaler feeds all channels.

module key_debounce_lane #(
  parameter int CW         = 10,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic CLK_50,
  input  logic nCR,
  input  logic tick,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic lng,
  output logic rpt
);
  typedef enum logic [2:0] {IDLE, DEB_DN, HELD, LONG, DEB_UP} state_t;

  localparam logic          REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic          REP_ON    = (REPEAT_EN != 0);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_TICKS - 1);

  logic [1:0]    sync_q;
  logic          pressed;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          level_nx, press_nx, rls_nx, lng_nx, rpt_nx;

  // Sync flops reset to the released level so reset never looks like a press.
  always_ff @(posedge CLK_50 or negedge nCR)
    if (!nCR) sync_q <= {2{REL_LVL}};
    else      sync_q <= {sync_q[0], key_raw};

  assign pressed = sync_q[1] ^ REL_LVL;

  always_ff @(posedge CLK_50 or negedge nCR)
    if (!nCR) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rls   <= 1'b0;
      lng   <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      press <= press_nx;
      rls   <= rls_nx;
      lng   <= lng_nx;
      rpt   <= rpt_nx;
    end

  // A level change always beats the tick in the same cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    press_nx = 1'b0;
    rls_nx   = 1'b0;
    lng_nx   = 1'b0;
    rpt_nx   = 1'b0;
    case (state)
      IDLE:
        if (pressed) state_nx = DEB_DN;
      DEB_DN:
        if (!pressed) state_nx = IDLE;
        else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_nx = HELD;
            level_nx = 1'b1;
            press_nx = 1'b1;
          end else cnt_nx = cnt + CW'(1);
        end
      HELD:
        if (!pressed) state_nx = DEB_UP;
        else if (tick) begin
          if (cnt == LONG_LAST) begin
            state_nx = LONG;
            lng_nx   = 1'b1;
          end else cnt_nx = cnt + CW'(1);
        end
      LONG:
        if (!pressed) state_nx = DEB_UP;
        else if (tick) begin
          if (cnt == REP_LAST) begin
            rpt_nx = REP_ON;
            cnt_nx = '0;
          end else cnt_nx = cnt + CW'(1);
        end
      DEB_UP:
        if (pressed) state_nx = HELD;
        else if (tick) begin
          if (cnt == DEB_LAST) begin
            state_nx = IDLE;
            level_nx = 1'b0;
            rls_nx   = 1'b1;
          end else cnt_nx = cnt + CW'(1);
        end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end
endmodule

module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              CLK_50,
  input  logic              nCR,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);
  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAX_DL = (DEB_TICKS > LONG_TICKS) ? DEB_TICKS : LONG_TICKS;
  localparam int MAX_T  = (MAX_DL > REP_TICKS) ? MAX_DL : REP_TICKS;
  localparam int CW     = $clog2(MAX_T + 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(DIV - 1));

  always_ff @(posedge CLK_50 or negedge nCR)
    if (!nCR)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else          pre_cnt <= pre_cnt + PW'(1);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .CW(CW), .DEB_TICKS(DEB_TICKS), .LONG_TICKS(LONG_TICKS),
      .REP_TICKS(REP_TICKS), .REPEAT_EN(REPEAT_EN), .ACTIVE_LOW(ACTIVE_LOW)
    ) u_lane (
      .CLK_50 (CLK_50),
      .nCR    (nCR),
      .tick   (tick),
      .key_raw(key_in[i]),
      .level  (key_level[i]),
      .press  (key_press[i]),
      .rls    (key_release[i]),
      .lng    (key_long[i]),
      .rpt    (key_repeat[i])
    );
  end
endmodule
